// File: rtl/lfsr_ext_counter.sv
// ---------------------------------------------------------------------------
// LfsrExtCounter (module lfsr_ext_counter)
//
// Purpose:
//   Fibonacci LFSR counter with state extension, so the sequence visits all
//   2^WIDTH patterns (including all-zero). Terminal count produces a
//   combinational carry (Next) for cascading. The counter can wrap or stop
//   once (one-shot, with a sticky Done flag).
//
// Optional feature macro: LFSR_CNT_MATCH_EN
//   Defined     -> Match_Val port exists and replaces the fixed terminal
//                  pattern, turning the wrap mode into a short modulo counter.
//   Not defined -> terminal pattern is fixed at {1'b1, 0...0}.
//
// Ports:
//   Clk        in   clock, all state changes on its rising edge
//   Rst        in   synchronous active-high reset (Q=0, Done=0)
//   CNT        in   count enable, one advance per enabled cycle
//   Load       in   synchronous load strobe (beats CNT)
//   Load_Val   in   [WIDTH] pattern loaded when Load=1
//   Mode       in   0 = wrap, 1 = one-shot
//   Match_Val  in   [WIDTH] terminal pattern (only with LFSR_CNT_MATCH_EN)
//   Q_Out      out  [WIDTH] current LFSR state
//   Next       out  combinational terminal-count carry
//   Done       out  registered sticky one-shot completion flag
// ---------------------------------------------------------------------------
module lfsr_ext_counter #(
  parameter int WIDTH = 6
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             CNT,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_Val,
  input  logic             Mode,
`ifdef LFSR_CNT_MATCH_EN
  input  logic [WIDTH-1:0] Match_Val,
`endif
  output logic [WIDTH-1:0] Q_Out,
  output logic             Next,
  output logic             Done
);

  // Only the widths covered by the primitive-polynomial table are usable.
  if (WIDTH < 3 || WIDTH > 16) begin : g_badWidth
    $error("lfsr_ext_counter: WIDTH must be in 3..16");
  end

  // Tap mask per width; tap t of the polynomial is state bit t-1.
  function automatic logic [15:0] tapMask(input int w);
    case (w)
      3:       tapMask = 16'h0006;
      4:       tapMask = 16'h000C;
      5:       tapMask = 16'h0014;
      6:       tapMask = 16'h0030;
      7:       tapMask = 16'h0060;
      8:       tapMask = 16'h00B8;
      9:       tapMask = 16'h0110;
      10:      tapMask = 16'h0240;
      11:      tapMask = 16'h0500;
      12:      tapMask = 16'h0829;
      13:      tapMask = 16'h100D;
      14:      tapMask = 16'h2015;
      15:      tapMask = 16'h6000;
      16:      tapMask = 16'hD008;
      default: tapMask = 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]      TAP_MASK = tapMask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAP_MASK[WIDTH-1:0];

  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] termPattern;
  logic             feedback;
  logic             atTerm;

`ifdef LFSR_CNT_MATCH_EN
  assign termPattern = Match_Val;
`else
  assign termPattern = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // The extra XOR with (low bits == 0) splices the all-zero state into the
  // maximal-length cycle: 0 -> 0..01, and {1,0..0} -> 0 instead of 0..01.
  assign feedback = (^(q_q & TAPS)) ^ (q_q[WIDTH-2:0] == '0);
  assign atTerm   = (q_q == termPattern);

  // Carry is suppressed while a load, a completed one-shot or reset is active.
  assign Next = CNT & ~Load & ~done_q & atTerm & ~Rst;

  // Next-state selection: load beats counting; at terminal count the
  // counter either wraps to zero or parks on the terminal pattern and
  // raises Done. Forcing zero on wrap also makes a programmable match
  // behave as a modulo counter.
  always_comb begin
    q_d    = q_q;
    done_d = done_q;
    if (Load) begin
      q_d    = Load_Val;
      done_d = 1'b0;
    end else if (Next) begin
      if (Mode) begin
        done_d = 1'b1;
      end else begin
        q_d = '0;
      end
    end else if (CNT && !done_q) begin
      q_d = {q_q[WIDTH-2:0], feedback};
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      q_q    <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      done_q <= done_d;
    end
  end

  assign Q_Out = q_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_lfsr_ext_counter.sv
// ---------------------------------------------------------------------------
// Testbench for lfsr_ext_counter.
// A WIDTH=4 instance is driven cycle by cycle against a scoreboard whose
// model walks the documented 16-state sequence. WIDTH=6 and WIDTH=16
// instances free-run in parallel and are checked for full, unique coverage.
// ---------------------------------------------------------------------------
module tb_lfsr_ext_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance signals
  logic       rst, cnt, load, mode;
  logic [3:0] loadVal, matchVal;
  logic [3:0] qOut;
  logic       next, done;

  // Free-running extension instances
  logic        rstExt, cntExt, loadExt, modeExt;
  logic [5:0]  zero6;
  logic [15:0] zero16;
  logic [5:0]  matchVal6;
  logic [15:0] matchVal16;
  logic [5:0]  q6;
  logic [15:0] q16;
  logic        next6, done6, next16, done16;
  logic        extDone;

  int checks = 0;
  int errors = 0;

  // Scoreboard state
  logic [3:0] seqList [16];
  logic [3:0] succ [16];
  logic [3:0] mQ;
  logic       mDone;
  logic [3:0] term;
  logic [4:0] expQ [$];

  lfsr_ext_counter #(.WIDTH(4)) dut4 (
    .Clk(clk), .Rst(rst), .CNT(cnt), .Load(load), .Load_Val(loadVal),
    .Mode(mode),
`ifdef LFSR_CNT_MATCH_EN
    .Match_Val(matchVal),
`endif
    .Q_Out(qOut), .Next(next), .Done(done)
  );

  lfsr_ext_counter #(.WIDTH(6)) dut6 (
    .Clk(clk), .Rst(rstExt), .CNT(cntExt), .Load(loadExt), .Load_Val(zero6),
    .Mode(modeExt),
`ifdef LFSR_CNT_MATCH_EN
    .Match_Val(matchVal6),
`endif
    .Q_Out(q6), .Next(next6), .Done(done6)
  );

  lfsr_ext_counter #(.WIDTH(16)) dut16 (
    .Clk(clk), .Rst(rstExt), .CNT(cntExt), .Load(loadExt), .Load_Val(zero16),
    .Mode(modeExt),
`ifdef LFSR_CNT_MATCH_EN
    .Match_Val(matchVal16),
`endif
    .Q_Out(q16), .Next(next16), .Done(done16)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of stimulus, check the combinational carry, push the
  // expected post-edge state, then pop and compare it after the edge.
  task automatic applyStimulus(input logic rstIn, input logic loadIn,
                               input logic cntIn, input logic modeIn,
                               input logic [3:0] lvIn);
    logic       expNext;
    logic [4:0] exp;
    @(negedge clk);
    rst     = rstIn;
    load    = loadIn;
    cnt     = cntIn;
    mode    = modeIn;
    loadVal = lvIn;
    #1;
    expNext = cntIn & ~loadIn & ~mDone & (mQ == term) & ~rstIn;
    checkOutput("next", 32'(next), 32'(expNext));
    if (rstIn) begin
      mQ = 4'h0; mDone = 1'b0;
    end else if (loadIn) begin
      mQ = lvIn; mDone = 1'b0;
    end else if (cntIn && !mDone) begin
      if (mQ == term) begin
        if (modeIn) mDone = 1'b1;
        else        mQ = 4'h0;
      end else begin
        mQ = succ[mQ];
      end
    end
    expQ.push_back({mQ, mDone});
    @(posedge clk);
    #1;
    exp = expQ.pop_front();
    checkOutput("q", 32'(qOut), 32'(exp[4:1]));
    checkOutput("done", 32'(done), 32'(exp[0]));
  endtask

  // Full-period coverage of the WIDTH=6 and WIDTH=16 instances.
  initial begin : extRun
    bit seen6 [64];
    bit seen16 [65536];
    int dup6, dup16;
    dup6 = 0; dup16 = 0;
    rstExt = 1'b1; cntExt = 1'b0; loadExt = 1'b0; modeExt = 1'b0;
    zero6 = '0; zero16 = '0;
    matchVal6 = 6'h20; matchVal16 = 16'h8000;
    extDone = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstExt = 1'b0;
    cntExt = 1'b1;
    for (int i = 0; i <= 65536; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 64) begin
        if (seen6[q6]) dup6++;
        seen6[q6] = 1'b1;
      end
      if (i == 64) begin
        checkOutput("w6Unique", 32'(dup6), 32'd0);
        checkOutput("w6Return", 32'(q6), 32'd0);
      end
      if (i < 65536) begin
        if (seen16[q16]) dup16++;
        seen16[q16] = 1'b1;
      end
    end
    checkOutput("w16Unique", 32'(dup16), 32'd0);
    checkOutput("w16Return", 32'(q16), 32'd0);
    extDone = 1'b1;
  end

  initial begin : mainRun
    seqList = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD,
                4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    for (int i = 0; i < 16; i++) succ[seqList[i]] = seqList[(i + 1) % 16];
    mQ = 4'h0; mDone = 1'b0; term = 4'h8; matchVal = 4'h8;
    rst = 1'b1; cnt = 1'b0; load = 1'b0; mode = 1'b0; loadVal = 4'h0;

    // Reset state
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    // Wrap sequence over a full period plus one
    repeat (17) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    // Hold with counting disabled
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // One-shot: parks on terminal pattern, Done sticky across Mode change
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    // Reset beats load and count while Done is set
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h3);

    // Load beats count at terminal pattern
    repeat (15) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'hC);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);

    // Reset mid-count at Q=D
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    repeat (7) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h5);

    // Load clears Done in one-shot mode, then one-shot completes again
    repeat (16) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'h8);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);

    // Random mix of all controls
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(15) == 0), 1'($urandom_range(4) == 0),
                    1'($urandom_range(3) != 0), 1'($urandom_range(1)),
                    4'($urandom_range(15)));
    end

`ifdef LFSR_CNT_MATCH_EN
    // Programmable terminal: modulo counter and the all-zero match
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    matchVal = 4'h9; term = 4'h9;
    repeat (12) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    matchVal = 4'h0; term = 4'h0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    matchVal = 4'h8; term = 4'h8;
`endif

    // Bounded wait for the free-running coverage process
    for (int i = 0; i < 70000 && !extDone; i++) @(posedge clk);
    checkOutput("extFinished", 32'(extDone), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
